// File: rtl/dmem_pkg.sv
// dmem_pkg: types and constants shared by the line responder and its storage.
//   dmem_state_e      - responder FSM states (IDLE, BUSY, ACK)
//   LINE_W            - width of one cache line in bits
//   LINE_OFFSET_BITS  - byte-offset bits inside a line (ignored for indexing)
//   CNT_W             - width of the latency counter (covers LATENCY 1..255)
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } dmem_state_e;

    localparam int LINE_W           = 256;
    localparam int LINE_OFFSET_BITS = 5;
    localparam int CNT_W            = 8;

endpackage

// File: rtl/dmem_line_array.sv
// dmem_line_array: DEPTH x LINE_W line storage behind the responder.
//   clk     - clock
//   rst     - synchronous active-high reset; clears only the read register,
//             the storage itself is never reset
//   wr_en   - commit wr_data into line idx at this edge
//   rd_en   - load line idx into the read register at this edge
//   idx     - line index
//   wr_data - line to be written
//   rd_data - registered read line; holds between read enables
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LINE_AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [LINE_AW-1:0] idx,
    input  logic [LINE_W-1:0]  wr_data,
    output logic [LINE_W-1:0]  rd_data
);

    logic [LINE_W-1:0] mem_r [DEPTH];
    logic [LINE_W-1:0] rd_data_r;

    // Write port: a reset edge never commits, so an aborted write is lost.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_r[idx] <= wr_data;
        end
    end

    // Registered read port: loads only on a read enable, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {LINE_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[idx];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/dmem_line_responder.sv
// dmem_line_responder: memory-side responder for the 256-bit line interface.
// Accepts one line read or write, waits LATENCY cycles, then pulses ack_o
// for one cycle; read data is presented with that ack.
//   clk_i    - clock
//   rst_i    - synchronous active-high reset (aborts any transaction)
//   enable_i - request valid (sampled only in IDLE)
//   write_i  - 1 = line write, 0 = line read
//   addr_i   - byte address; line index is addr[LINE_AW+4:5]
//   data_i   - write line
//   ack_o    - registered one-cycle completion pulse
//   data_o   - registered read line, held between read acks
module dmem_line_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512,
    parameter int LINE_AW = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY - 1);
    localparam bit               DIRECT_ACK = (LATENCY == 1);

    dmem_state_e          state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [LINE_AW-1:0]   req_idx_r;
    logic [LINE_W-1:0]    req_data_r;
    logic                 req_write_r;
    logic                 ack_r;

    logic                 accept_s;
    logic                 go_ack_s;
    logic [LINE_AW-1:0]   idx_s;
    logic [LINE_W-1:0]    wdata_s;
    logic                 write_s;
    logic                 wr_en_s;
    logic                 rd_en_s;
    logic [LINE_W-1:0]    rd_data_s;
    logic                 unused_addr_bits_s;

    // Offset bits and bits above the index are don't-care: the space wraps.
    assign unused_addr_bits_s = ^{addr_i[31:LINE_AW+LINE_OFFSET_BITS],
                                  addr_i[LINE_OFFSET_BITS-1:0]};

    // Decide acceptance and the edge that enters ACK. With LATENCY=1 the
    // memory access happens at the acceptance edge itself, so the array is
    // fed from the live inputs while IDLE and from the request registers
    // otherwise.
    always_comb begin
        accept_s = 1'b0;
        go_ack_s = 1'b0;
        idx_s    = req_idx_r;
        wdata_s  = req_data_r;
        write_s  = req_write_r;
        if (rst_i) begin
            accept_s = 1'b0;
            go_ack_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    accept_s = enable_i;
                    go_ack_s = enable_i & DIRECT_ACK;
                    idx_s    = addr_i[LINE_AW+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];
                    wdata_s  = data_i;
                    write_s  = write_i;
                end
                BUSY: begin
                    go_ack_s = (cnt_r == 8'd1);
                end
                ACK: begin
                    go_ack_s = 1'b0;
                end
                default: begin
                    go_ack_s = 1'b0;
                end
            endcase
        end
    end

    assign wr_en_s = go_ack_s & write_s;
    assign rd_en_s = go_ack_s & ~write_s;

    // Responder FSM: request capture, latency counter and registered ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            req_idx_r   <= {LINE_AW{1'b0}};
            req_data_r  <= {LINE_W{1'b0}};
            req_write_r <= 1'b0;
            ack_r       <= 1'b0;
        end else begin
            ack_r <= go_ack_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        req_idx_r   <= idx_s;
                        req_data_r  <= data_i;
                        req_write_r <= write_i;
                        cnt_r       <= CNT_LOAD;
                        state_r     <= DIRECT_ACK ? ACK : BUSY;
                    end
                end
                BUSY: begin
                    // Inputs are ignored here; a dropped enable does not cancel.
                    cnt_r <= cnt_r - 8'd1;
                    if (go_ack_s) begin
                        state_r <= ACK;
                    end
                end
                ACK: begin
                    // Never accept out of ACK; the next request waits for IDLE.
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ack_o = ack_r;

    dmem_line_array #(
        .DEPTH   (DEPTH),
        .LINE_AW (LINE_AW)
    ) u_array (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (wr_en_s),
        .rd_en   (rd_en_s),
        .idx     (idx_s),
        .wr_data (wdata_s),
        .rd_data (rd_data_s)
    );

    assign data_o = rd_data_s;

endmodule
